hm01b0_pixel_capture: RTL

// Captures HM01B0 parallel pixel bytes into the osc_12m domain and buffers them as a valid/ready byte stream.

---
 rtl/hm01b0_pixel_capture_if.sv | 29 ++
 rtl/hm01b0_pixel_capture.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hm01b0_pixel_capture_if.sv
// ----------------------------------------------------------------------------
// hm01b0_pixel_capture_if
// Output byte stream of the HM01B0 pixel capture block.
//   out_data  [7:0]  pixel byte at the FIFO head
//   out_sof          head byte is the first pixel of a frame
//   out_sol          head byte is the first pixel of a line
//   out_valid        FIFO non-empty
//   out_ready        consumer accepts the head when out_valid & out_ready
// The master modport is used by the capture block; the slave by the consumer.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface hm01b0_pixel_capture_if;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_sol;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data, out_sof, out_sol, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_sof, out_sol, out_valid,
        output out_ready
    );
endinterface

// File: rtl/hm01b0_pixel_capture.sv
// ----------------------------------------------------------------------------
// hm01b0_pixel_capture
// Captures HM01B0 parallel pixel bytes into the system clock domain and
// buffers them in a small FIFO presented as a valid/ready byte stream.
// Also reports per-frame pixel/line totals and counts pixels dropped when
// the FIFO is full.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   enable              capture enable, sampled when a frame starts
//   pixclk/hsync/vsync  camera strobes (asynchronous)
//   pixdata [7:0]       camera pixel byte (asynchronous)
//   out                 output stream (hm01b0_pixel_capture_if.master)
//   frame_done          one-cycle pulse at the end of a captured frame
//   frame_pixels        pixels seen in the last completed frame (incl. dropped)
//   frame_lines [11:0]  lines seen in the last completed frame
//   drop_count [15:0]   saturating count of pixels dropped on overflow
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module hm01b0_pixel_capture #(
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  pixclk,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [7:0]            pixdata,
    hm01b0_pixel_capture_if.master out,
    output logic                  frame_done,
    output logic [CNT_W-1:0]      frame_pixels,
    output logic [11:0]           frame_lines,
    output logic [15:0]           drop_count
);

    localparam int                DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE = 1;
    localparam logic [CNT_W-1:0]   PIX_ONE = 1;

    typedef enum logic [1:0] {ST_SYNC, ST_ARMED, ST_FRAME} state_e;

    // ---------------- input synchronizers: {pixclk, hsync, vsync, pixdata}
    logic [10:0] sync_s1_q, sync_s2_q;
    logic        pixclk_s3_q, hsync_s3_q, vsync_s3_q;
    // settle_q[1] marks that sync_s2_q holds a real sample rather than the
    // reset value, so SYNC cannot mistake a high vsync for a low one.
    logic [1:0]  settle_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_s1_q   <= '0;
            sync_s2_q   <= '0;
            pixclk_s3_q <= 1'b0;
            hsync_s3_q  <= 1'b0;
            vsync_s3_q  <= 1'b0;
            settle_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old
            // value of its neighbour, which is what makes this a shift chain.
            sync_s1_q   <= {pixclk, hsync, vsync, pixdata};
            sync_s2_q   <= sync_s1_q;
            pixclk_s3_q <= sync_s2_q[10];
            hsync_s3_q  <= sync_s2_q[9];
            vsync_s3_q  <= sync_s2_q[8];
            settle_q    <= {settle_q[0], 1'b1};
        end
    end

    logic       pixclk_s2, hsync_s2, vsync_s2;
    logic [7:0] pixdata_s2;
    logic       px_edge, vs_rise, vs_fall, hs_rise;

    assign pixclk_s2  = sync_s2_q[10];
    assign hsync_s2   = sync_s2_q[9];
    assign vsync_s2   = sync_s2_q[8];
    assign pixdata_s2 = sync_s2_q[7:0];
    assign px_edge    = pixclk_s2 & ~pixclk_s3_q;
    assign vs_rise    = vsync_s2 & ~vsync_s3_q;
    assign vs_fall    = ~vsync_s2 & vsync_s3_q;
    assign hs_rise    = hsync_s2 & ~hsync_s3_q;

    // ---------------- FIFO
    logic [9:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               full, not_empty, pop, wr_en, accept;
    logic [9:0]         wr_word, head;

    state_e state_q, state_d;
    logic   sof_pend_q, sof_pend_d, sol_pend_q, sol_pend_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, frame_pixels_q, frame_pixels_d;
    logic [11:0]      line_cnt_q, line_cnt_d, frame_lines_q, frame_lines_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      drop_q;

    assign not_empty = (count_q != '0);
    assign full      = count_q[FIFO_AW];       // count reaches DEPTH only when full
    assign pop       = not_empty & out.out_ready;
    assign accept    = (state_q == ST_FRAME) & px_edge & vsync_s2 & hsync_s2;
    // A pop in the same cycle frees the slot the full FIFO needs.
    assign wr_en     = accept & (~full | pop);
    // A line that starts on this very cycle marks this pixel as its first.
    assign wr_word   = {sof_pend_q, sol_pend_q | hs_rise, pixdata_s2};
    assign head      = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; emptiness is tracked by count_q
    // and the outputs are gated while empty, so stale contents never leak.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (accept && !wr_en && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    // ---------------- frame FSM and counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_SYNC;
            sof_pend_q     <= 1'b0;
            sol_pend_q     <= 1'b0;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            frame_pixels_q <= '0;
            frame_lines_q  <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sof_pend_q     <= sof_pend_d;
            sol_pend_q     <= sol_pend_d;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            frame_pixels_q <= frame_pixels_d;
            frame_lines_q  <= frame_lines_d;
            frame_done_q   <= frame_done_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned, which would infer a latch.
        state_d        = state_q;
        sof_pend_d     = sof_pend_q;
        sol_pend_d     = sol_pend_q;
        pix_cnt_d      = pix_cnt_q;
        line_cnt_d     = line_cnt_q;
        frame_pixels_d = frame_pixels_q;
        frame_lines_d  = frame_lines_q;
        frame_done_d   = 1'b0;
        case (state_q)
            ST_SYNC: begin
                // Discard any frame already in progress when reset released.
                if (settle_q[1] && !vsync_s2) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (vs_rise && enable) begin
                    state_d    = ST_FRAME;
                    sof_pend_d = 1'b1;
                    sol_pend_d = 1'b1;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                end
            end
            ST_FRAME: begin
                if (hs_rise) begin
                    sol_pend_d = 1'b1;
                    line_cnt_d = line_cnt_q + 12'd1;
                end
                if (accept) begin
                    pix_cnt_d = pix_cnt_q + PIX_ONE;
                    // A dropped byte leaves the markers for the next stored one.
                    if (wr_en) begin
                        sof_pend_d = 1'b0;
                        sol_pend_d = 1'b0;
                    end
                end
                if (vs_fall) begin
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_d;
                    frame_lines_d  = line_cnt_d;
                    state_d        = ST_ARMED;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    assign out.out_valid = not_empty;
    assign out.out_data  = not_empty ? head[7:0] : 8'h00;
    assign out.out_sol   = not_empty & head[8];
    assign out.out_sof   = not_empty & head[9];
    assign frame_done    = frame_done_q;
    assign frame_pixels  = frame_pixels_q;
    assign frame_lines   = frame_lines_q;
    assign drop_count    = drop_q;

endmodule
